// File: rtl/slavefifo2b_stream_in_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : slavefifo2b_stream_in_buffer_if
//  Description : Bundles the application stream, FX3 flag inputs and the
//                slave-FIFO write-side outputs of the stream-in buffer.
//                The slave modport is the buffer's view; master is the
//                environment's view (application source plus FX3 flag feed).
//  Signals     : enable, app_data, app_valid, app_ready, flush,
//                flaga_d, flagb_d, slwr_, pktend_, data_out, level,
//                pkt_word_cnt, busy
//  Revision    : 1.0 - initial release
// ============================================================================
interface slavefifo2b_stream_in_buffer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int PKT_WORDS  = 256
);
  localparam int c_LW = $clog2(DEPTH) + 1;
  localparam int c_CW = $clog2(PKT_WORDS) + 1;

  logic                  enable;
  logic [DATA_WIDTH-1:0] app_data;
  logic                  app_valid;
  logic                  app_ready;
  logic                  flush;
  logic                  flaga_d;
  logic                  flagb_d;
  logic                  slwr_;
  logic                  pktend_;
  logic [DATA_WIDTH-1:0] data_out;
  logic [c_LW-1:0]       level;
  logic [c_CW-1:0]       pkt_word_cnt;
  logic                  busy;

  modport slave (
    input  enable, app_data, app_valid, flush, flaga_d, flagb_d,
    output app_ready, slwr_, pktend_, data_out, level, pkt_word_cnt, busy
  );

  modport master (
    output enable, app_data, app_valid, flush, flaga_d, flagb_d,
    input  app_ready, slwr_, pktend_, data_out, level, pkt_word_cnt, busy
  );
endinterface
`default_nettype wire

// File: rtl/slavefifo2b_stream_in_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : slavefifo2b_stream_in_buffer
//  Description : Stream-in feeder for the FX3 slave-FIFO write socket.
//                Application words are buffered in a small FIFO and written
//                out with slwr_ whenever the registered FX3 flags allow it.
//                Full DMA buffers are committed by the FX3 itself; partial
//                packets are closed with a one-cycle pktend_ on a flush
//                request or after an idle timeout.
//  Ports       : clk_100  - interface clock
//                reset    - synchronous active-high reset
//                sif      - slave modport: app valid/ready stream, flush,
//                           flaga_d/flagb_d (active-low, registered),
//                           slwr_/pktend_/data_out toward the FX3 mux,
//                           level/pkt_word_cnt/busy status
//  Revision    : 1.0 - initial release
// ============================================================================
module slavefifo2b_stream_in_buffer #(
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 16,
  parameter int PKT_WORDS     = 256,
  parameter int IDLE_TIMEOUT  = 64,
  parameter int SETTLE_CYCLES = 3
) (
  input  wire logic                     clk_100,
  input  wire logic                     reset,
  slavefifo2b_stream_in_buffer_if.slave sif
);

  // --------------------------------------------------------------------------
  // Derived widths and constants
  // --------------------------------------------------------------------------
  localparam int c_AW = $clog2(DEPTH);
  localparam int c_LW = c_AW + 1;
  localparam int c_CW = $clog2(PKT_WORDS) + 1;
  localparam int c_TW = $clog2(IDLE_TIMEOUT + 1);
  localparam int c_SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [c_LW-1:0] c_FULL        = c_LW'(DEPTH);
  localparam logic [c_CW-1:0] c_PKT_LAST    = c_CW'(PKT_WORDS - 1);
  localparam logic [c_TW-1:0] c_TMO         = c_TW'(IDLE_TIMEOUT);
  localparam logic [c_SW-1:0] c_SETTLE_LAST = c_SW'(SETTLE_CYCLES - 1);

  localparam logic [2:0] c_ST_IDLE      = 3'd0;
  localparam logic [2:0] c_ST_WRITE     = 3'd1;
  localparam logic [2:0] c_ST_WAIT_FLAG = 3'd2;
  localparam logic [2:0] c_ST_SETTLE    = 3'd3;
  localparam logic [2:0] c_ST_DRAIN     = 3'd4;
  localparam logic [2:0] c_ST_PKTEND    = 3'd5;

  // --------------------------------------------------------------------------
  // State and storage
  // --------------------------------------------------------------------------
  logic [2:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [c_AW-1:0]       wr_ptr_q;
  logic [c_AW-1:0]       rd_ptr_q;
  logic [c_LW-1:0]       level_q;
  logic [c_CW-1:0]       cnt_q;
  logic [c_TW-1:0]       timer_q;
  logic [c_SW-1:0]       settle_q;
  logic                  flush_pend_q;
  logic                  slwr_q;
  logic [DATA_WIDTH-1:0] data_q;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic w_app_ready;
  logic w_pktend_n;
  logic w_busy;
  logic w_push;
  logic w_pop;
  logic w_wrap;
  logic w_empty;
  logic w_open;
  logic w_flags_ok;
  logic w_flush_req;

  assign w_empty    = (level_q == '0);
  assign w_open     = (cnt_q != '0);
  assign w_flags_ok = sif.flaga_d & sif.flagb_d;
  assign w_push     = sif.app_valid & w_app_ready;

  // A write is issued only from WRITE or DRAIN, and only with both flags
  // sampled good on this very edge; the FX3 watermark slack absorbs the
  // one-cycle age of the registered flags.
  assign w_pop  = ((state_q == c_ST_WRITE) || (state_q == c_ST_DRAIN)) &&
                  !w_empty && w_flags_ok;
  assign w_wrap = w_pop && (cnt_q == c_PKT_LAST);

  // Partial-packet commit request: explicit flush (live or pending) or an
  // expired idle timer. Acted upon only once the buffer is empty.
  assign w_flush_req = flush_pend_q | sif.flush | (timer_q == c_TMO);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_100) begin
    if (reset) begin
      state_q <= c_ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_IDLE: begin
        if (sif.enable) state_d = c_ST_WRITE;
      end
      c_ST_WRITE: begin
        if (!w_flags_ok) begin
          state_d = c_ST_WAIT_FLAG;
        end else if (w_wrap) begin
          state_d = c_ST_SETTLE;
        end else if (w_flush_req && w_empty && w_open) begin
          state_d = c_ST_PKTEND;
        end else if (!sif.enable) begin
          state_d = c_ST_DRAIN;
        end
      end
      c_ST_WAIT_FLAG: begin
        if (w_flags_ok) state_d = sif.enable ? c_ST_WRITE : c_ST_DRAIN;
      end
      c_ST_SETTLE: begin
        if (settle_q == c_SETTLE_LAST) state_d = sif.enable ? c_ST_WRITE : c_ST_DRAIN;
      end
      c_ST_DRAIN: begin
        // Never commit a zero-length packet: close only if words were sent.
        if (w_empty) state_d = w_open ? c_ST_PKTEND : c_ST_IDLE;
      end
      c_ST_PKTEND: begin
        state_d = sif.enable ? c_ST_WRITE : c_ST_IDLE;
      end
      default: begin
        state_d = c_ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_app_ready = 1'b0;
    w_pktend_n  = 1'b1;
    w_busy      = 1'b0;
    // Intake is closed while draining or committing so that the packet being
    // closed cannot grow underneath the pktend_ decision.
    w_app_ready = sif.enable && (level_q < c_FULL) &&
                  (state_q != c_ST_DRAIN) && (state_q != c_ST_PKTEND);
    w_pktend_n  = (state_q != c_ST_PKTEND);
    w_busy      = (state_q != c_ST_IDLE);
  end

  // --------------------------------------------------------------------------
  // Buffer storage (no reset needed: contents are qualified by level)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_100) begin
    if (w_push) mem_q[wr_ptr_q] <= sif.app_data;
  end

  // --------------------------------------------------------------------------
  // Datapath: pointers, occupancy, write strobe, packet and timer counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_100) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      cnt_q        <= '0;
      timer_q      <= '0;
      settle_q     <= '0;
      flush_pend_q <= 1'b0;
      slwr_q       <= 1'b1;
      data_q       <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;

      case ({w_push, w_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase

      // data_out keeps its last value between writes.
      slwr_q <= ~w_pop;
      if (w_pop) data_q <= mem_q[rd_ptr_q];

      // Words-in-packet counter; a full DMA buffer wraps it back to zero
      // since the FX3 commits that buffer on its own.
      if (state_q == c_ST_PKTEND) begin
        cnt_q <= '0;
      end else if (w_pop) begin
        cnt_q <= w_wrap ? '0 : cnt_q + 1'b1;
      end

      // Idle timer runs only while a partial packet sits open with nothing
      // buffered; any traffic restarts it.
      if (w_push || w_pop || !((state_q == c_ST_WRITE) && w_empty && w_open)) begin
        timer_q <= '0;
      end else if (timer_q != c_TMO) begin
        timer_q <= timer_q + 1'b1;
      end

      settle_q <= (state_q == c_ST_SETTLE) ? settle_q + 1'b1 : '0;

      // Flush bookkeeping. A request with nothing sent and nothing buffered
      // has no packet to close and is dropped; a pending request is also
      // dropped if the packet closed itself on a DMA-buffer boundary.
      if ((state_d == c_ST_PKTEND) && (state_q != c_ST_PKTEND)) begin
        flush_pend_q <= 1'b0;
      end else if (sif.flush && (w_open || !w_empty)) begin
        flush_pend_q <= 1'b1;
      end else if (!w_open && w_empty) begin
        flush_pend_q <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign sif.app_ready    = w_app_ready;
  assign sif.slwr_        = slwr_q;
  assign sif.pktend_      = w_pktend_n;
  assign sif.data_out     = data_q;
  assign sif.level        = level_q;
  assign sif.pkt_word_cnt = cnt_q;
  assign sif.busy         = w_busy;

endmodule
`default_nettype wire
